// File: rtl/booth_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_W     = 8;
  localparam int BOOTH_STEPS = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [BOOTH_W:0] sext9(input logic [BOOTH_W-1:0] v);
    return {v[BOOTH_W-1], v};
  endfunction

endpackage

// File: rtl/booth_addsub9.sv
// 9-bit accumulator add/subtract of sign-extended multiplicand; subtract is invert-plus-carry-in.
module booth_addsub9
  import booth_pkg::*;
(
  input  logic [BOOTH_W:0]   acc_i,
  input  logic [BOOTH_W-1:0] m_i,
  input  logic               sub_i,
  output logic [BOOTH_W:0]   sum_o
);

  logic [BOOTH_W:0] operand;

  assign operand = sext9(m_i) ^ {(BOOTH_W+1){sub_i}};
  assign sum_o   = acc_i + operand + {{BOOTH_W{1'b0}}, sub_i};

endmodule

// File: rtl/booth_multiplier_8x8.sv
// Sequential 8x8 signed radix-2 Booth multiplier with en-held / ready-pulse handshake.
// Optional BOOTH_MULT_TRACE_EN macro adds simulation-only step and result trace output.
module booth_multiplier_8x8
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BOOTH_W-1:0]   A,
  input  logic [BOOTH_W-1:0]   B,
  output logic [2*BOOTH_W-1:0] Output,
  output logic                 ready
);

  state_e               state_q;
  logic [BOOTH_W-1:0]   m_q;
  logic [BOOTH_W-1:0]   q_q,   q_d;
  logic [BOOTH_W:0]     acc_q, acc_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*BOOTH_W-1:0] out_q;
  logic                 ready_q;

  logic [BOOTH_W:0]     sum;
  logic [BOOTH_W:0]     step_acc;
  logic                 last_step;

  // {Q[0], q-1} = 10 subtracts, 01 adds; the sub select is simply Q[0].
  booth_addsub9 u_addsub (
    .acc_i (acc_q),
    .m_i   (m_q),
    .sub_i (q_q[0]),
    .sum_o (sum)
  );

  always_comb begin
    step_acc  = (q_q[0] ^ qm1_q) ? sum : acc_q;
    acc_d     = {step_acc[BOOTH_W], step_acc[BOOTH_W:1]};
    q_d       = {step_acc[0], q_q[BOOTH_W-1:1]};
    qm1_d     = q_q[0];
    last_step = (cnt_q == CNT_W'(BOOTH_STEPS - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          m_q     <= A;
          q_q     <= B;
          acc_q   <= '0;
          qm1_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            out_q   <= {acc_d[BOOTH_W-1:0], q_d};
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Output = out_q;
  assign ready  = ready_q;

`ifdef BOOTH_MULT_TRACE_EN
  logic [BOOTH_W-1:0] b_trace_q;

  always_ff @(posedge clk) begin
    if (!rst && en && state_q == IDLE) b_trace_q <= B;
    if (!rst && en && state_q == BUSY) begin
      $display("[booth] step %0d acc=%h q=%h q-1=%b", cnt_q, acc_d, q_d, qm1_d);
      if (last_step)
        $display("[booth] done A=%h B=%h Output=%h", m_q, b_trace_q, {acc_d[BOOTH_W-1:0], q_d});
    end
  end
`else
`endif

endmodule

// File: tb/tb_booth_multiplier_8x8.sv
// Directed self-checking bench for booth_multiplier_8x8: vector table plus abort/reset/operand-change sequences.
module tb_booth_multiplier_8x8;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] Output;
  logic        ready;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[9];

  booth_multiplier_8x8 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .A      (A),
    .B      (B),
    .Output (Output),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full operation from IDLE: 9 edges with en high, then en low for one edge.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] prod);
    A  = a;
    B  = b;
    en = 1'b1;
    for (int e = 1; e <= 8; e++) tick();
    check({name, " ready low at edge 8"}, {15'd0, ready}, 16'd0);
    tick();
    check({name, " ready"}, {15'd0, ready}, 16'd1);
    check({name, " product"}, Output, prod);
    en = 1'b0;
    tick();
    check({name, " ready drop"}, {15'd0, ready}, 16'd0);
    check({name, " product held"}, Output, prod);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    en  = 1'b0;
    A   = '0;
    B   = '0;

    vecs[0] = '{8'hF9, 8'h06, 16'hFFD6};  // -7 * 6   = -42
    vecs[1] = '{8'h7F, 8'h80, 16'hC080};  // 127*-128 = -16256
    vecs[2] = '{8'h80, 8'h80, 16'h4000};  // -128*-128 = 16384
    vecs[3] = '{8'h00, 8'hFF, 16'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h80, 8'h7F, 16'hC080};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};  // 16129
    vecs[7] = '{8'hFF, 8'h80, 16'h0080};  // -1*-128 = 128
    vecs[8] = '{8'h0C, 8'hF3, 16'hFF64};  // 12*-13 = -156

    tick();
    tick();
    check("reset Output", Output, 16'h0000);
    check("reset ready", {15'd0, ready}, 16'd0);
    rst = 1'b0;
    tick();

    // 3 x 5 with per-edge latency check and ready held while en stays high
    A  = 8'd3;
    B  = 8'd5;
    en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("3x5 ready low edge %0d", e), {15'd0, ready}, 16'd0);
    end
    tick();
    check("3x5 ready edge 9", {15'd0, ready}, 16'd1);
    check("3x5 product", Output, 16'h000F);
    A = 8'h55;
    B = 8'hAA;
    tick();
    tick();
    check("3x5 ready held", {15'd0, ready}, 16'd1);
    check("3x5 product held in DONE", Output, 16'h000F);
    en = 1'b0;
    tick();
    check("3x5 ready drop", {15'd0, ready}, 16'd0);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod);

    // Abort: complete 3x5, start 10x10, drop en after edge 4, then restart
    run_op("abort pre 3x5", 8'd3, 8'd5, 16'h000F);
    A  = 8'd10;
    B  = 8'd10;
    en = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    en = 1'b0;
    tick();
    check("abort ready", {15'd0, ready}, 16'd0);
    check("abort Output kept", Output, 16'h000F);
    run_op("abort restart 10x10", 8'd10, 8'd10, 16'h0064);

    // Operand change during BUSY is ignored
    A  = 8'd10;
    B  = 8'd10;
    en = 1'b1;
    tick();
    A = 8'h33;
    B = 8'h77;
    for (int e = 2; e <= 9; e++) tick();
    check("opchange ready", {15'd0, ready}, 16'd1);
    check("opchange product", Output, 16'h0064);
    en = 1'b0;
    tick();

    // Reset at edge 5 of a 10x10 run, then a fresh run with en held high
    A  = 8'd10;
    B  = 8'd10;
    en = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();
    check("midreset Output", Output, 16'h0000);
    check("midreset ready", {15'd0, ready}, 16'd0);
    rst = 1'b0;
    run_op("post reset -7x6", 8'hF9, 8'h06, 16'hFFD6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_8x8.md
# booth_multiplier_8x8

Sequential 8x8 signed (two's-complement) radix-2 Booth multiplier producing a 16-bit product. Sits behind the r0 arithmetic multiplexer as its MUL engine. Uses the same enable-held / ready-pulse handshake as the adder and complement units, so the multiplexer drives `en` high and samples `Output` when `ready` is 1.

## Interface
- No parameters. Width 8 and step count 8 are fixed constants (see Structure).
- `clk` in, 1 bit: rising-edge clock. One clock domain; reset is synchronous and active-high.
- `rst` in, 1 bit: synchronous, active-high reset.
- `en` in, 1 bit: start/hold request. Held high for the whole operation.
- `A` in, 8 bits: multiplicand, signed.
- `B` in, 8 bits: multiplier, signed.
- `Output` out, 16 bits: signed product A*B. Registered.
- `ready` out, 1 bit: product valid. Registered.

## Operation
- States:
  - IDLE: waiting for `en`.
  - BUSY: performing Booth steps.
  - DONE: product valid.
- IDLE with `en`=1:
  - Capture M=A and Q=B.
  - Clear the 9-bit accumulator ACC, the extra bit q₋₁ and the step counter.
  - Go to BUSY.
- BUSY with `en`=1: one Booth step per cycle, selected by {Q[0], q₋₁}.
  - 01: ACC += sext9(M).
  - 10: ACC −= sext9(M), computed as ACC + ~sext9(M) + 1.
  - 00 or 11: no add.
  - Then arithmetic right shift of {ACC, Q, q₋₁} by 1 (ACC[8] replicated).
  - Counter increments.
- On the 8th step:
  - `Output` ← {ACC[7:0], Q} taken after the shift.
  - `ready` ← 1.
  - Go to DONE.
- ACC is 9 bits so that M = −128 cannot overflow. Products −128·−128 = 0x4000 and −128·127 are exact.
- DONE with `en`=1: hold `Output` and `ready`=1. Changes on A or B are ignored.
- `en`=0 in any state:
  - Go to IDLE next edge with `ready`=0.
  - `Output` keeps its last value.
  - A BUSY computation is abandoned with no partial result.
- A and B are sampled only at the capture edge. Changes during BUSY have no effect.
- A new multiplication requires `en` to be low for at least one cycle.

## Timing
- Reset values: `Output`=16'h0000, `ready`=0, state IDLE, ACC, Q, q₋₁ and counter all 0.
- `rst` has priority over `en`. Reset mid-operation clears everything on the same edge.
- Latency, counted in rising edges with `en`=1 starting from IDLE:
  - Edge 1 captures the operands.
  - Edges 2–9 perform the eight steps.
  - `ready` and `Output` become valid after edge 9.
- `en` deasserted: `ready` falls after the next edge.
- Back-to-back operations: after DONE, `en` low for 1 cycle, then high. Minimum period is 10 cycles per product.
- No combinational path from inputs to outputs.

## Configuration
- `BOOTH_MULT_TRACE_EN`
  - Defined: each BUSY step emits a simulation `$display` of step index, ACC, Q and q₋₁. DONE emits A, B and `Output`.
  - Not defined: no display statements are compiled. Cycle behaviour is identical either way.

## Structure
- Shared package `booth_pkg`:
  - State enum (IDLE, BUSY, DONE).
  - `BOOTH_W` = 8.
  - `BOOTH_STEPS` = 8.
  - Counter width = 4.
- One sub-module `booth_addsub9`:
  - Combinational 9-bit add/subtract of ACC and sext9(M), selected by a `sub` input.
  - Subtract as invert-plus-carry-in, in the style of the codebase's ripple_cla8 and twos_compliment units.
- Top level holds the FSM, the shift registers and the output registers.

## Test plan
- A=3, B=5, `en` held high → `ready`=0 through edge 8, `ready`=1 after edge 9, `Output`=16'h000F. `ready` stays 1 while `en` high.
- Signed mixes:
  - A=−7 (8'hF9), B=6 → 16'hFFD6.
  - A=127, B=−128 → 16'hC080.
  - A=−128, B=−128 → 16'h4000.
- A=0, B=8'hFF → 16'h0000. A=8'hFF, B=8'hFF → 16'h0001.
- Abort:
  - Complete 3×5 first.
  - Restart with A=10, B=10 and drop `en` after edge 4 → `ready`=0 and `Output` stays 16'h000F.
  - Re-raise `en` → 16'h0064 after 9 edges.
- Operand change: change A and B during BUSY → product still reflects the values captured at edge 1.
- Reset mid-operation: assert `rst` at edge 5 of a 10×10 run → `Output`=0, `ready`=0, state IDLE. A new run after reset completes normally.
